eth_fifo_pkt_reader: RTL and testbench
======================================

// Module: eth_fifo_pkt_reader
// PURPOSE
//  Drain side of the 8-bit Ethernet byte FIFO (2048 deep, sync, no output register). Decides packet
//  boundaries, requests a UDP transmission, and streams FIFO bytes into the UDP TX engine on its
//  byte-request handshake. Sits between the FIFO read port and the UDP/MAC transmit path.
// PARAMETERS
//  PKT_LEN      1024    full packet payload, bytes (legal 1..1472)
//  TIMEOUT_CYC  125000  idle cycles before a partial packet is flushed (1 ms at 125 MHz)
//  LEVEL_W      12      width of fifo_level (FIFO depth width + 1)
// PORTS
//  clk            in   1        system clock, shared with the FIFO and UDP TX
//  rst            in   1        synchronous reset, active-high
//  fifo_rd_en     out  1        FIFO read enable; data valid on fifo_rd_data the next cycle
//  fifo_rd_data   in   8        FIFO read data
//  fifo_rd_empty  in   1        FIFO empty flag
//  fifo_level     in   LEVEL_W  FIFO read water level, bytes currently stored
//  tx_start_en    out  1        one-cycle pulse: start a UDP packet
//  tx_byte_num    out  16       payload length of the requested packet, held stable until tx_done
//  tx_req         in   1        UDP TX wants a byte; it samples tx_data on the following cycle
//  tx_data        out  8        payload byte to UDP TX
//  tx_done        in   1        one-cycle pulse: UDP TX finished the packet
//  busy           out  1        high in every state except IDLE
//  pkt_cnt        out  16       packets completed (wraps 0xFFFF->0)
//  err_underflow  out  1        sticky: tx_req arrived with the FIFO empty while bytes were still owed
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; timer, byte counter and rd_vld cleared. Reset mid-packet returns to
//   IDLE immediately. Bytes already read are discarded. The FIFO shares rst, so no stale data remains.
//  FSM IDLE -> REQ -> STREAM -> WAIT_DONE -> IDLE.
//  IDLE: timer counts while 0 < fifo_level < PKT_LEN. It clears when fifo_level==0 or fifo_level>=PKT_LEN.
//   If fifo_level>=PKT_LEN: len=PKT_LEN, go to REQ.
//   Else if timer==TIMEOUT_CYC-1 and fifo_level!=0: len=fifo_level (captured that cycle), go to REQ.
//   fifo_level==0 never starts a packet.
//  REQ: tx_start_en=1 for exactly this cycle. tx_byte_num=len, zero-extended to 16 bits.
//   tx_byte_num is latched here and held until IDLE. Next state is STREAM.
//  STREAM:
//   fifo_rd_en = tx_req & (sent<len) & ~fifo_rd_empty.
//   sent increments on each fifo_rd_en. When sent reaches len, go to WAIT_DONE.
//   tx_req with sent==len is ignored: no read.
//   tx_req & (sent<len) & fifo_rd_empty: no read, set err_underflow (cleared only by rst).
//  Data path: rd_vld is fifo_rd_en registered. tx_data = rd_vld ? fifo_rd_data : 8'h00.
//   The byte appears 1 cycle after tx_req, matching the UDP TX sampling point.
//  WAIT_DONE: on tx_done, pkt_cnt+=1, go to IDLE. tx_done in any other state is ignored.
//  Back-to-back: a new packet may start the cycle after returning to IDLE. The timer restarts from 0.
//  Width rules: sent and len are 16-bit. fifo_level is zero-extended for comparison.
// TESTING
//  1) Write 1024 bytes 0x00..0xFF repeating. -> tx_start_en 1 pulse, tx_byte_num=1024.
//     Continuous tx_req -> 1024 rd_en cycles; tx_data matches in order.
//     tx_done -> pkt_cnt=1, busy=0.
//  2) Write 10 bytes, then idle. -> no start for TIMEOUT_CYC-1 cycles.
//     Then start with tx_byte_num=10; exactly 10 reads; FIFO empty afterwards.
//  3) Write 2100 bytes. -> packet of 1024; after tx_done, a second packet of 1024.
//     The remaining 52 bytes flush after the timeout. pkt_cnt=3.
//  4) Gapped tx_req (1 on, 2 off) with extra tx_req after the last byte. -> exactly len reads;
//     tx_data=0 on non-valid cycles; err_underflow=0.
//  5) Assert rst at byte 500 of a 1024 packet (FIFO reset too). -> next cycle all outputs 0, state IDLE.
//     A fresh 1024-byte write produces a normal packet.
//  6) Force fifo_rd_empty=1 mid-STREAM with tx_req. -> fifo_rd_en=0, err_underflow=1.
//     It stays 1 until rst.

Source files
------------

// File: rtl/eth_fifo_pkt_reader.sv
// Drain side of the Ethernet byte FIFO: decides packet boundaries, requests a UDP transmission
// and streams FIFO bytes into the UDP TX engine on its byte-request handshake.
module eth_fifo_pkt_reader #(
  parameter int unsigned PKT_LEN     = 1024,
  parameter int unsigned TIMEOUT_CYC = 125000,
  parameter int unsigned LEVEL_W     = 12
) (
  input  logic               clk,
  input  logic               rst,
  output logic               fifo_rd_en,
  input  logic [7:0]         fifo_rd_data,
  input  logic               fifo_rd_empty,
  input  logic [LEVEL_W-1:0] fifo_level,
  output logic               tx_start_en,
  output logic [15:0]        tx_byte_num,
  input  logic               tx_req,
  output logic [7:0]         tx_data,
  input  logic               tx_done,
  output logic               busy,
  output logic [15:0]        pkt_cnt,
  output logic               err_underflow
);

  localparam int unsigned TimerW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {StIdle, StReq, StStream, StWaitDone} state_e;

  state_e            state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       sent_q, sent_d;
  logic [15:0]       pkt_cnt_q, pkt_cnt_d;
  logic              err_q, err_d;
  logic              rd_vld_q;

  logic [31:0] level_ext;
  logic        level_zero;
  logic        level_full;
  logic        timeout;
  logic        owed;
  logic        rd_fire;

  assign level_ext  = 32'(fifo_level);
  assign level_zero = (fifo_level == '0);
  assign level_full = (level_ext >= PKT_LEN);
  assign timeout    = (timer_q == TimerW'(TIMEOUT_CYC - 1));
  assign owed       = (sent_q < len_q);
  assign rd_fire    = (state_q == StStream) && tx_req && owed && !fifo_rd_empty;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q   <= '0;
      len_q     <= '0;
      sent_q    <= '0;
      pkt_cnt_q <= '0;
      err_q     <= 1'b0;
      rd_vld_q  <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      len_q     <= len_d;
      sent_q    <= sent_d;
      pkt_cnt_q <= pkt_cnt_d;
      err_q     <= err_d;
      rd_vld_q  <= rd_fire;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    timer_d   = '0;
    len_d     = len_q;
    sent_d    = sent_q;
    pkt_cnt_d = pkt_cnt_q;
    err_d     = err_q;
    unique case (state_q)
      StIdle: begin
        sent_d = '0;
        if (!level_zero && !level_full) begin
          timer_d = timer_q + 1'b1;
        end
        // A full packet wins over the flush of a partial one.
        if (level_full) begin
          len_d   = 16'(PKT_LEN);
          timer_d = '0;
          state_d = StReq;
        end else if (timeout && !level_zero) begin
          len_d   = 16'(fifo_level);
          timer_d = '0;
          state_d = StReq;
        end
      end
      StReq: begin
        state_d = StStream;
      end
      StStream: begin
        if (rd_fire) begin
          sent_d = sent_q + 16'd1;
          if (sent_q + 16'd1 == len_q) begin
            state_d = StWaitDone;
          end
        end
        if (tx_req && owed && fifo_rd_empty) begin
          err_d = 1'b1;
        end
      end
      StWaitDone: begin
        if (tx_done) begin
          pkt_cnt_d = pkt_cnt_q + 16'd1;
          state_d   = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs
  always_comb begin
    fifo_rd_en    = rd_fire;
    tx_start_en   = (state_q == StReq);
    busy          = (state_q != StIdle);
    tx_byte_num   = len_q;
    pkt_cnt       = pkt_cnt_q;
    err_underflow = err_q;
    // FIFO has no output register: the byte is valid the cycle after the read.
    tx_data       = rd_vld_q ? fifo_rd_data : 8'h00;
  end

endmodule

// File: tb/tb_eth_fifo_pkt_reader.sv
// Bench for eth_fifo_pkt_reader: a queue-based FIFO and UDP TX responder drive the reader;
// expected bytes and packet lengths are queued at write time and popped by the TX-side monitor.
module tb_eth_fifo_pkt_reader;

  localparam int unsigned PKT_LEN     = 1024;
  localparam int unsigned TIMEOUT_CYC = 64;
  localparam int unsigned LEVEL_W     = 12;

  logic               clk = 1'b0;
  logic               rst;
  logic               fifo_rd_en;
  logic [7:0]         fifo_rd_data = 8'h00;
  logic               fifo_rd_empty;
  logic [LEVEL_W-1:0] fifo_level = '0;
  logic               tx_start_en;
  logic [15:0]        tx_byte_num;
  logic               tx_req;
  logic [7:0]         tx_data;
  logic               tx_done;
  logic               busy;
  logic [15:0]        pkt_cnt;
  logic               err_underflow;
  logic               force_empty;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  byte unsigned wr_q[$];
  byte unsigned fifo_q[$];
  byte unsigned exp_bytes[$];
  int           exp_len[$];

  int unsigned mode_sel;
  int          exp_pkt;
  bit          exp_err;
  bit          active;
  bit          chk_done;
  int          got;
  int          n_starts;
  int          start_cyc;

  eth_fifo_pkt_reader #(
    .PKT_LEN     (PKT_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .LEVEL_W     (LEVEL_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .fifo_rd_en    (fifo_rd_en),
    .fifo_rd_data  (fifo_rd_data),
    .fifo_rd_empty (fifo_rd_empty),
    .fifo_level    (fifo_level),
    .tx_start_en   (tx_start_en),
    .tx_byte_num   (tx_byte_num),
    .tx_req        (tx_req),
    .tx_data       (tx_data),
    .tx_done       (tx_done),
    .busy          (busy),
    .pkt_cnt       (pkt_cnt),
    .err_underflow (err_underflow)
  );

  always #4 clk = ~clk;

  assign fifo_rd_empty = (fifo_level == '0) || force_empty;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Sync FIFO without output register; a whole write burst lands in one cycle.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      fifo_q.delete();
      wr_q.delete();
      fifo_rd_data <= 8'h00;
    end else begin
      if (fifo_rd_en) begin
        if (fifo_q.size() > 0) fifo_rd_data <= fifo_q.pop_front();
        else fifo_rd_data <= 8'hEE;
      end
      while (wr_q.size() > 0) fifo_q.push_back(wr_q.pop_front());
    end
    fifo_level <= LEVEL_W'(fifo_q.size());
  end

  // UDP TX responder and output monitor, acting on the falling edge.
  initial begin : tx_side
    int owed_m;
    int extra_left;
    int gap;
    int dly;
    int mode;
    int blen;
    bit due;
    bit just_started;
    bit fire;
    logic [7:0] eb;
    tx_req = 1'b0;
    tx_done = 1'b0;
    due = 1'b0;
    just_started = 1'b0;
    owed_m = 0; extra_left = 0; gap = 0; dly = 0; mode = 0;
    active = 1'b0; chk_done = 1'b0; got = 0; n_starts = 0; start_cyc = 0;
    exp_pkt = 0; exp_err = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        active = 1'b0; due = 1'b0; chk_done = 1'b0; just_started = 1'b0;
        tx_req = 1'b0; tx_done = 1'b0; exp_pkt = 0; exp_err = 1'b0;
        continue;
      end
      tx_done = 1'b0;
      if (chk_done) begin
        check("pkt_cnt", pkt_cnt, exp_pkt);
        check("busy_after_done", busy, 0);
        check("err_underflow", err_underflow, exp_err);
        chk_done = 1'b0;
      end
      if (due) begin
        eb = 'x;
        if (exp_bytes.size() > 0) eb = exp_bytes.pop_front();
        check("tx_data", tx_data, eb);
        got++;
      end else if (active) begin
        check("tx_data_idle", tx_data, 0);
      end
      if (tx_start_en) begin
        check("start_while_active", active, 0);
        blen = (exp_len.size() > 0) ? exp_len.pop_front() : -1;
        check("tx_byte_num", tx_byte_num, blen);
        n_starts++;
        start_cyc = cyc;
        active = 1'b1;
        owed_m = (blen > 0) ? blen : int'(tx_byte_num);
        got = 0; extra_left = 2; gap = 0; mode = int'(mode_sel);
        dly = $urandom_range(0, 4);
        just_started = 1'b1;
      end
      due = 1'b0;
      tx_req = 1'b0;
      if (active && !just_started) begin
        if (owed_m > 0 || extra_left > 0) begin
          case (mode)
            0: fire = 1'b1;
            1: fire = (gap == 0);
            default: fire = ($urandom_range(0, 2) == 0);
          endcase
          gap = (gap == 2) ? 0 : gap + 1;
          if (fire) begin
            tx_req = 1'b1;
            if (owed_m > 0) begin
              if (force_empty) exp_err = 1'b1;
              else begin
                due = 1'b1;
                owed_m--;
              end
            end else begin
              extra_left--;
            end
          end
          // Stray done pulses mid-stream must be ignored.
          if (owed_m > 0 && $urandom_range(0, 63) == 0) tx_done = 1'b1;
        end else if (dly > 0) begin
          dly--;
        end else begin
          tx_done = 1'b1;
          exp_pkt = (exp_pkt + 1) % 65536;
          active = 1'b0;
          chk_done = 1'b1;
        end
      end
      just_started = 1'b0;
      #1;
      if (tx_req) check("fifo_rd_en", fifo_rd_en, due);
    end
  end

  task automatic write_bytes(input int n, input bit rnd);
    byte unsigned b;
    int rem;
    for (int i = 0; i < n; i++) begin
      b = rnd ? byte'($urandom_range(0, 255)) : byte'(i % 256);
      wr_q.push_back(b);
      exp_bytes.push_back(b);
    end
    rem = n;
    while (rem >= int'(PKT_LEN)) begin
      exp_len.push_back(PKT_LEN);
      rem -= PKT_LEN;
    end
    if (rem > 0) exp_len.push_back(rem);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int i;
    i = 0;
    while ((exp_len.size() != 0 || active || busy || chk_done || fifo_level != 0) && i < budget) begin
      @(posedge clk); #1;
      i++;
    end
    n_tests++;
    if (i >= budget) begin
      n_fail++;
      $display("FAIL %s: idle not reached within %0d cycles", name, budget);
    end
  endtask

  task automatic wait_got(input string name, input int n);
    int i;
    i = 0;
    while (!(active && got >= n) && i < 20000) begin
      @(posedge clk); #1;
      i++;
    end
    n_tests++;
    if (i >= 20000) begin
      n_fail++;
      $display("FAIL %s: %0d bytes not streamed in time, got %0d", name, n, got);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_en"}, fifo_rd_en, 0);
    check({tag, "_start"}, tx_start_en, 0);
    check({tag, "_byte_num"}, tx_byte_num, 0);
    check({tag, "_tx_data"}, tx_data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_pkt_cnt"}, pkt_cnt, 0);
    check({tag, "_err"}, err_underflow, 0);
  endtask

  initial begin : stim
    int w;
    int s0;
    int i;
    rst = 1'b1;
    force_empty = 1'b0;
    mode_sel = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // Full packet, incrementing pattern, continuous requests
    write_bytes(1024, 1'b0);
    wait_idle("t1_idle", 20000);
    check("t1_pkt_cnt", pkt_cnt, 1);

    // Short burst flushed exactly after the idle timeout
    w = cyc;
    s0 = n_starts;
    write_bytes(10, 1'b1);
    i = 0;
    while (n_starts == s0 && i < int'(TIMEOUT_CYC) + 50) begin
      @(posedge clk); #1;
      i++;
    end
    check("t2_start_latency", start_cyc - w, TIMEOUT_CYC + 1);
    wait_idle("t2_idle", 20000);
    check("t2_fifo_level", fifo_level, 0);

    // Two full packets back to back, then a 52-byte flush
    write_bytes(2100, 1'b1);
    wait_idle("t3_idle", 30000);
    check("t3_pkt_cnt", pkt_cnt, 5);

    // Gapped requests with extra requests after the last byte
    mode_sel = 1;
    write_bytes(300, 1'b1);
    wait_idle("t4_idle", 20000);
    check("t4_err", err_underflow, 0);

    // Empty FIFO while bytes are still owed
    mode_sel = 0;
    write_bytes(1024, 1'b1);
    wait_got("t6_progress", 100);
    force_empty = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
    end
    force_empty = 1'b0;
    wait_idle("t6_idle", 20000);
    check("t6_err_sticky", err_underflow, 1);

    // Reset in the middle of a packet
    write_bytes(1024, 1'b1);
    wait_got("t5_progress", 500);
    rst = 1'b1;
    exp_bytes.delete();
    exp_len.delete();
    @(posedge clk); #1;
    check_reset_outputs("midrst");
    rst = 1'b0;
    write_bytes(1024, 1'b1);
    wait_idle("t5_idle", 20000);
    check("t5_pkt_cnt", pkt_cnt, 1);

    // Randomised bursts and request patterns
    repeat (6) begin
      mode_sel = $urandom_range(0, 2);
      write_bytes($urandom_range(1, 1500), 1'b1);
      wait_idle("rand_idle", 30000);
      check("rand_bytes_left", exp_bytes.size(), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #(900_000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
